vram_arbiter: RTL and testbench

- Downstream of the 6502 external-bus interface. Consumes its single-byte bus-master transactions and arbitrates them against 32-bit video-fetch requests for the shared 128 KB VRAM.
- VRAM is one synchronous 32K x 32 RAM with byte write enables.
- Also decodes the 19-bit bus-master address into VRAM, an I/O slave window, or an unmapped region.
- Bus master has absolute priority and a fixed 1-cycle read latency. Video port uses a req/ack handshake.

---
 rtl/vram_arb_pkg.sv | 34 +++
 rtl/vram_arb_rdmux.sv | 61 ++++++
 rtl/vram_arbiter.sv | 101 ++++++++++
 tb/tb_vram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM arbiter: region encoding, address-width
// defaults, region-decode constants and the byte-lane write-mask helper.
package vram_arb_pkg;

    localparam int VRAM_AW = 15;  // VRAM word-address width (32-bit words)
    localparam int IO_AW   = 17;  // I/O window byte-address width
    localparam int BM_AW   = 19;  // bus-master byte-address width

    typedef enum logic [1:0] {
        REG_VRAM     = 2'd0,
        REG_IO       = 2'd1,
        REG_UNMAPPED = 2'd2
    } region_e;

    // Values of bm_addr[18:17] selecting each window; anything else is unmapped.
    localparam logic [1:0] DEC_VRAM = 2'b00;
    localparam logic [1:0] DEC_IO   = 2'b01;

    function automatic region_e decode_region(input logic [1:0] addr_hi);
        region_e r;
        case (addr_hi)
            DEC_VRAM: r = REG_VRAM;
            DEC_IO:   r = REG_IO;
            default:  r = REG_UNMAPPED;
        endcase
        return r;
    endfunction

    // One-hot byte enable for a byte lane within a 32-bit word (lane 0 -> 4'b0001).
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/vram_arb_rdmux.sv
// Bus-master read return path: remembers what kind of read was issued, selects
// the right byte in the following cycle, and holds it until the next read.
module vram_arb_rdmux
    import vram_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_issue,    // read strobe accepted this cycle
    input  region_e     rd_region_d,
    input  logic [1:0]  rd_lane_d,
    input  logic [31:0] ram_rddata,
    input  logic [7:0]  io_rddata,
    output logic [7:0]  rd_data
);

    logic        rd_pending;
    region_e     rd_region;
    logic [1:0]  rd_lane;
    logic [7:0]  rd_sel;
    logic [7:0]  rd_hold;

    // Capture read context so the return mux knows where the data comes from.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pending <= 1'b0;
            rd_region  <= REG_UNMAPPED;
            rd_lane    <= 2'd0;
        end else begin
            rd_pending <= rd_issue;
            if (rd_issue) begin
                rd_region <= rd_region_d;
                rd_lane   <= rd_lane_d;
            end
        end
    end

    // Select the returned byte from the source that served the read.
    // NOTE: defaults are assigned first so no path through the block leaves
    // rd_sel unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_sel = 8'h00;
        case (rd_region)
            REG_VRAM: rd_sel = ram_rddata[8*rd_lane +: 8];
            REG_IO:   rd_sel = io_rddata;
            default:  rd_sel = 8'h00;
        endcase
    end

    // Keep the last returned byte visible between reads.
    // NOTE: the hold register is a plain flop and is reset, so bm_rddata is a
    // defined 8'h00 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             rd_hold <= 8'h00;
        else if (rd_pending) rd_hold <= rd_sel;
    end

    assign rd_data = rd_pending ? rd_sel : rd_hold;

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates single-byte bus-master accesses against 32-bit video fetches on a
// shared 32K x 32 synchronous VRAM, and decodes bus-master addresses into
// VRAM / I/O / unmapped windows. Bus master has absolute priority.
// Optional conflict counter enabled by defining VRAM_ARB_PERF_EN.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int VRAM_AW = vram_arb_pkg::VRAM_AW,
    parameter int IO_AW   = vram_arb_pkg::IO_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [18:0]        bm_addr,
    input  logic [7:0]         bm_wrdata,
    input  logic               bm_strobe,
    input  logic               bm_write,
    output logic [7:0]         bm_rddata,
    output logic               io_strobe,
    output logic               io_write,
    output logic [IO_AW-1:0]   io_addr,
    output logic [7:0]         io_wrdata,
    input  logic [7:0]         io_rddata,
    input  logic               vid_req,
    input  logic [VRAM_AW-1:0] vid_addr,
    output logic               vid_ack,
    output logic               vid_rdvalid,
    output logic [31:0]        vid_rddata,
    output logic [VRAM_AW-1:0] ram_addr,
    output logic [31:0]        ram_wrdata,
    output logic [3:0]         ram_wrmask,
    output logic               ram_write,
    input  logic [31:0]        ram_rddata,
    output logic [15:0]        conflict_cnt
);

    region_e     region;
    logic        bm_vram;
    logic [31:0] vid_hold;

    assign region  = decode_region(bm_addr[18:17]);
    assign bm_vram = bm_strobe && (region == REG_VRAM);
    assign vid_ack = vid_req && !bm_vram;

    // Drive the RAM and I/O ports from the winning requester in the same cycle.
    always_comb begin
        ram_addr   = vid_addr;
        ram_wrdata = {4{bm_wrdata}};
        ram_wrmask = 4'b0000;
        ram_write  = 1'b0;
        io_strobe  = bm_strobe && (region == REG_IO);
        io_write   = bm_strobe && (region == REG_IO) && bm_write;
        io_addr    = bm_addr[IO_AW-1:0];
        io_wrdata  = bm_wrdata;
        if (bm_vram) begin
            ram_addr = bm_addr[VRAM_AW+1:2];
            if (bm_write) begin
                ram_wrmask = lane_mask(bm_addr[1:0]);
                ram_write  = 1'b1;
            end
        end
    end

    vram_arb_rdmux u_rdmux (
        .clk         (clk),
        .rst         (rst),
        .rd_issue    (bm_strobe && !bm_write),
        .rd_region_d (region),
        .rd_lane_d   (bm_addr[1:0]),
        .ram_rddata  (ram_rddata),
        .io_rddata   (io_rddata),
        .rd_data     (bm_rddata)
    );

    // Video return: flag the cycle the RAM presents an acked word, keep the word after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_rdvalid <= 1'b0;
            vid_hold    <= 32'h0;
        end else begin
            vid_rdvalid <= vid_ack;
            if (vid_rdvalid) vid_hold <= ram_rddata;
        end
    end

    assign vid_rddata = vid_rdvalid ? ram_rddata : vid_hold;

`ifdef VRAM_ARB_PERF_EN
    logic [15:0] conflict_q;

    // Count cycles a pending video request was blocked, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          conflict_q <= 16'h0000;
        else if (vid_req && !vid_ack && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural 32K x 32
// synchronous RAM. Inputs change 1ns after the rising edge; outputs are
// sampled 1ns later, well clear of the next edge.
module tb_vram_arbiter;

`ifdef VRAM_ARB_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] bm_addr;
    logic [7:0]  bm_wrdata;
    logic        bm_strobe;
    logic        bm_write;
    logic [7:0]  bm_rddata;
    logic        io_strobe;
    logic        io_write;
    logic [16:0] io_addr;
    logic [7:0]  io_wrdata;
    logic [7:0]  io_rddata;
    logic        vid_req;
    logic [14:0] vid_addr;
    logic        vid_ack;
    logic        vid_rdvalid;
    logic [31:0] vid_rddata;
    logic [14:0] ram_addr;
    logic [31:0] ram_wrdata;
    logic [3:0]  ram_wrmask;
    logic        ram_write;
    logic [31:0] ram_rddata;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .bm_addr      (bm_addr),
        .bm_wrdata    (bm_wrdata),
        .bm_strobe    (bm_strobe),
        .bm_write     (bm_write),
        .bm_rddata    (bm_rddata),
        .io_strobe    (io_strobe),
        .io_write     (io_write),
        .io_addr      (io_addr),
        .io_wrdata    (io_wrdata),
        .io_rddata    (io_rddata),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .vid_ack      (vid_ack),
        .vid_rdvalid  (vid_rdvalid),
        .vid_rddata   (vid_rddata),
        .ram_addr     (ram_addr),
        .ram_wrdata   (ram_wrdata),
        .ram_wrmask   (ram_wrmask),
        .ram_write    (ram_write),
        .ram_rddata   (ram_rddata),
        .conflict_cnt (conflict_cnt)
    );

    // Behavioural VRAM: byte-masked write, registered read of the old word.
    logic [31:0] mem [0:32767];

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
        mem[15'h0002] = 32'h1122_3344;
        mem[15'h1234] = 32'hCAFE_F00D;
        mem[15'h1235] = 32'h0101_0101;
        mem[15'h1236] = 32'h0202_0202;
        mem[15'h1237] = 32'h0303_0303;
    end

    always @(posedge clk) begin
        ram_rddata <= mem[ram_addr];
        if (ram_write) begin
            for (int b = 0; b < 4; b++)
                if (ram_wrmask[b]) mem[ram_addr][8*b +: 8] <= ram_wrdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bm_idle();
        bm_strobe = 1'b0;
        bm_write  = 1'b0;
    endtask

    task automatic bm_issue(input logic [18:0] a, input logic wr, input logic [7:0] d);
        bm_addr   = a;
        bm_write  = wr;
        bm_wrdata = d;
        bm_strobe = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        ram_rddata = 32'h0;
        bm_addr    = 19'h0;
        bm_wrdata  = 8'h00;
        bm_strobe  = 1'b0;
        bm_write   = 1'b0;
        io_rddata  = 8'h00;
        vid_req    = 1'b0;
        vid_addr   = 15'h0;
        repeat (3) tick();
        rst = 1'b0;
        #1;

        // Reset state.
        check("rst_bm_rddata", bm_rddata, 8'h00);
        check("rst_vid_rdvalid", vid_rdvalid, 1'b0);
        check("rst_vid_rddata", vid_rddata, 32'h0);
        check("rst_conflict", conflict_cnt, 16'h0);
        check("rst_io_strobe", io_strobe, 1'b0);
        check("rst_ram_write", ram_write, 1'b0);
        check("rst_vid_ack", vid_ack, 1'b0);

        // IO write passes straight through in the strobe cycle.
        tick();
        bm_issue(19'h20010, 1'b1, 8'h5A);
        #1;
        check("io_wr_strobe", io_strobe, 1'b1);
        check("io_wr_write", io_write, 1'b1);
        check("io_wr_addr", io_addr, 17'h00010);
        check("io_wr_data", io_wrdata, 8'h5A);
        check("io_wr_no_ram", ram_write, 1'b0);
        tick();
        bm_idle();
        #1;
        check("io_wr_strobe_end", io_strobe, 1'b0);
        repeat (3) tick();

        // VRAM byte write to lane 2 of word 1.
        bm_issue(19'h00006, 1'b1, 8'hA5);
        #1;
        check("vw_write", ram_write, 1'b1);
        check("vw_mask", ram_wrmask, 4'b0100);
        check("vw_data", ram_wrdata, 32'hA5A5_A5A5);
        check("vw_addr", ram_addr, 15'h0001);
        check("vw_no_io", io_strobe, 1'b0);
        tick();
        bm_idle();
        repeat (3) tick();

        // Read it back: data at T+1, held at T+3.
        bm_issue(19'h00006, 1'b0, 8'h00);
        #1;
        check("vr_no_write", ram_write, 1'b0);
        check("vr_addr", ram_addr, 15'h0001);
        tick();
        bm_idle();
        #1;
        check("vr_t1", bm_rddata, 8'hA5);
        tick();
        tick();
        #1;
        check("vr_t3_hold", bm_rddata, 8'hA5);
        tick();

        // Video request collides with a VRAM read: bus master first, video next cycle.
        vid_addr = 15'h1234;
        vid_req  = 1'b1;
        bm_issue(19'h00008, 1'b0, 8'h00);
        #1;
        check("col_ack_blocked", vid_ack, 1'b0);
        check("col_ram_addr_bm", ram_addr, 15'h0002);
        tick();
        bm_idle();
        #1;
        check("col_ack_next", vid_ack, 1'b1);
        check("col_ram_addr_vid", ram_addr, 15'h1234);
        check("col_bm_rddata", bm_rddata, 8'h44);
        check("col_rdvalid_early", vid_rdvalid, 1'b0);
        tick();
        vid_req = 1'b0;
        #1;
        check("col_rdvalid", vid_rdvalid, 1'b1);
        check("col_rddata", vid_rddata, 32'hCAFE_F00D);
        tick();
        #1;
        check("col_rdvalid_pulse", vid_rdvalid, 1'b0);
        check("col_rddata_hold", vid_rddata, 32'hCAFE_F00D);
        check("col_conflict", conflict_cnt, PERF_EN ? 16'd1 : 16'd0);
        repeat (2) tick();

        // Streaming video alongside an IO read: ack every cycle, 1 word/clk.
        vid_addr  = 15'h1235;
        vid_req   = 1'b1;
        io_rddata = 8'h77;
        bm_issue(19'h20020, 1'b0, 8'h00);
        #1;
        check("str_ack0", vid_ack, 1'b1);
        check("str_io_strobe", io_strobe, 1'b1);
        check("str_io_read", io_write, 1'b0);
        tick();
        bm_idle();
        vid_addr = 15'h1236;
        #1;
        check("str_ack1", vid_ack, 1'b1);
        check("str_io_rd", bm_rddata, 8'h77);
        check("str_valid1", vid_rdvalid, 1'b1);
        check("str_data1", vid_rddata, 32'h0101_0101);
        tick();
        vid_addr  = 15'h1237;
        io_rddata = 8'h00;
        #1;
        check("str_ack2", vid_ack, 1'b1);
        check("str_io_hold", bm_rddata, 8'h77);
        check("str_valid2", vid_rdvalid, 1'b1);
        check("str_data2", vid_rddata, 32'h0202_0202);
        tick();
        vid_req = 1'b0;
        #1;
        check("str_valid3", vid_rdvalid, 1'b1);
        check("str_data3", vid_rddata, 32'h0303_0303);
        tick();
        #1;
        check("str_valid_end", vid_rdvalid, 1'b0);
        repeat (2) tick();

        // Unmapped read: no activity, returns zero even with live IO/RAM data.
        bm_issue(19'h40000, 1'b0, 8'h00);
        #1;
        check("um_no_io", io_strobe, 1'b0);
        check("um_no_ram", ram_write, 1'b0);
        tick();
        bm_idle();
        io_rddata = 8'h99;
        #1;
        check("um_rddata", bm_rddata, 8'h00);
        repeat (3) tick();

        // Reset asserted at T+1 of a VRAM read while a video fetch is in flight.
        vid_addr = 15'h1234;
        bm_issue(19'h00006, 1'b0, 8'h00);
        tick();
        bm_idle();
        vid_req = 1'b1;
        rst     = 1'b1;
        #1;
        check("mid_rst_bm_rddata", bm_rddata, 8'h00);
        check("mid_rst_rdvalid", vid_rdvalid, 1'b0);
        tick();
        vid_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        #1;
        check("post_rst_rdvalid", vid_rdvalid, 1'b0);
        check("post_rst_bm_rddata", bm_rddata, 8'h00);
        check("post_rst_conflict", conflict_cnt, 16'h0);

        // Held video request against three spaced VRAM strobes.
        vid_addr = 15'h1234;
        vid_req  = 1'b1;
        for (int s = 0; s < 3; s++) begin
            bm_issue(19'h00004, 1'b0, 8'h00);
            tick();
            bm_idle();
            repeat (3) tick();
        end
        vid_req = 1'b0;
        #1;
        check("perf_three", conflict_cnt, PERF_EN ? 16'd3 : 16'd0);

`ifdef VRAM_ARB_PERF_EN
        // Continuous blocking drives the counter into saturation.
        vid_req = 1'b1;
        bm_issue(19'h00004, 1'b0, 8'h00);
        repeat (70000) tick();
        bm_idle();
        vid_req = 1'b0;
        #1;
        check("perf_saturate", conflict_cnt, 16'hFFFF);
        tick();
        #1;
        check("perf_saturate_hold", conflict_cnt, 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
